// File: rtl/seg7_scan_ctrl_if.sv
// Load/display bundle for seg7_scan_ctrl: host-side data, dp, blank and load strobe, plus
// the pending/frame status and the board-facing anode/segment pins. Optional SEG7_DIM_EN adds bright_i.
interface seg7_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] data_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   blank_i;
  logic                    load_i;
`ifdef SEG7_DIM_EN
  logic [3:0]              bright_i;
`endif
  logic                    pending_o;
  logic                    frame_o;
  logic [NUM_DIGITS-1:0]   disp_an_o;
  logic [7:0]              disp_seg_o;

  modport master (
`ifdef SEG7_DIM_EN
    output bright_i,
`endif
    output data_i,
    output dp_i,
    output blank_i,
    output load_i,
    input  pending_o,
    input  frame_o,
    input  disp_an_o,
    input  disp_seg_o
  );

  modport slave (
`ifdef SEG7_DIM_EN
    input  bright_i,
`endif
    input  data_i,
    input  dp_i,
    input  blank_i,
    input  load_i,
    output pending_o,
    output frame_o,
    output disp_an_o,
    output disp_seg_o
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with a double-buffered, frame-aligned load.
// Define SEG7_DIM_EN to add per-slot PWM dimming driven by bus.bright_i.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned CLK_DIV    = 100000
) (
  input logic              clk,
  input logic              rst,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [DivW-1:0] LastDiv = DivW'(CLK_DIV - 1);

  // Segment pattern for a hex nibble, active-low {dp,g..a} with dp off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    unique case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  logic [DivW-1:0]         div_q, div_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d, pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d, pend_blank_q, pend_blank_d;
  logic                    pending_q, pending_d;
  logic                    frame_q, frame_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;

  logic                    tick, boundary, commit;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   slot_an;
  logic [7:0]              slot_seg;

`ifdef SEG7_DIM_EN
  logic [3:0]              bright_q, bright_d;
  logic [NUM_DIGITS-1:0]   slot_an_q, slot_an_d;
  logic [7:0]              slot_seg_q, slot_seg_d;
  logic [31:0]             on_limit;
  logic                    lit;
`endif

  always_comb begin
    tick     = (div_q == LastDiv);
    boundary = tick && (idx_q == LastIdx);
    commit   = boundary && pending_q;

    div_d = tick ? '0 : div_q + DivW'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
    end

    // Commit happens on the same edge that starts digit 0, so decode reads the bypassed value.
    disp_data_d  = commit ? pend_data_q  : disp_data_q;
    disp_dp_d    = commit ? pend_dp_q    : disp_dp_q;
    disp_blank_d = commit ? pend_blank_q : disp_blank_q;

    pend_data_d  = bus.load_i ? bus.data_i  : pend_data_q;
    pend_dp_d    = bus.load_i ? bus.dp_i    : pend_dp_q;
    pend_blank_d = bus.load_i ? bus.blank_i : pend_blank_q;
    pending_d    = bus.load_i | (pending_q & ~commit);

    frame_d = boundary;

    nib         = disp_data_d[{idx_d, 2'b00} +: 4];
    slot_seg    = hex_to_seg(nib);
    slot_seg[7] = ~disp_dp_d[idx_d];
    slot_an     = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d);
    if (disp_blank_d[idx_d]) begin
      slot_an  = '1;
      slot_seg = 8'hFF;
    end

`ifdef SEG7_DIM_EN
    bright_d   = tick ? bus.bright_i : bright_q;
    slot_an_d  = tick ? slot_an  : slot_an_q;
    slot_seg_d = tick ? slot_seg : slot_seg_q;
    on_limit   = ((32'(bright_d) + 32'd1) * CLK_DIV) >> 4;
    lit        = (32'(div_d) < on_limit);
    an_d       = lit ? slot_an_d  : '1;
    seg_d      = lit ? slot_seg_d : 8'hFF;
`else
    an_d  = tick ? slot_an  : an_q;
    seg_d = tick ? slot_seg : seg_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= LastIdx;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pending_q    <= 1'b0;
      frame_q      <= 1'b0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pending_q    <= pending_d;
      frame_q      <= frame_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

`ifdef SEG7_DIM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_q   <= '0;
      slot_an_q  <= '1;
      slot_seg_q <= 8'hFF;
    end else begin
      bright_q   <= bright_d;
      slot_an_q  <= slot_an_d;
      slot_seg_q <= slot_seg_d;
    end
  end
`endif

  assign bus.pending_o  = pending_q;
  assign bus.frame_o    = frame_q;
  assign bus.disp_an_o  = an_q;
  assign bus.disp_seg_o = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: a cycle-count based display model checked every
// falling edge, plus hand-computed expectations for the directed scenarios.
module tb_seg7_scan_ctrl;
  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: slot position follows from the number of clock edges since reset.
  logic [7:0]  seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          m_cnt = 0;
  int          m_ticks = 0;
  int          m_digit = -1;
  bit          m_frame = 0;
  bit          m_pend = 0;
  logic [15:0] m_pd_data = '0, m_dd_data = '0;
  logic [3:0]  m_pd_dp = '0, m_dd_dp = '0, m_pd_bl = '0, m_dd_bl = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_ticks = 0; m_digit = -1; m_frame = 0; m_pend = 0;
      m_pd_data = '0; m_dd_data = '0; m_pd_dp = '0; m_dd_dp = '0; m_pd_bl = '0; m_dd_bl = '0;
    end else begin
      m_frame = 0;
      if (m_cnt % DIV == DIV - 1) begin
        m_ticks++;
        m_digit = (m_ticks - 1) % N;
        if (m_digit == 0) begin
          m_frame = 1;
          if (m_pend) begin
            m_dd_data = m_pd_data; m_dd_dp = m_pd_dp; m_dd_bl = m_pd_bl;
            m_pend = 0;
          end
        end
      end
      if (bus.load_i) begin
        m_pd_data = bus.data_i; m_pd_dp = bus.dp_i; m_pd_bl = bus.blank_i;
        m_pend = 1;
      end
      m_cnt++;
    end
  end

  function automatic logic [3:0] exp_an();
    if (m_digit < 0 || m_dd_bl[m_digit]) return 4'hF;
    return ~(4'b0001 << m_digit);
  endfunction

  function automatic logic [7:0] exp_seg();
    logic [3:0] nib;
    if (m_digit < 0 || m_dd_bl[m_digit]) return 8'hFF;
    nib = m_dd_data[m_digit*4 +: 4];
    return seg_tbl[nib] & (m_dd_dp[m_digit] ? 8'h7F : 8'hFF);
  endfunction

  always @(negedge clk) begin
    check("model_an", bus.disp_an_o, exp_an());
    check("model_seg", bus.disp_seg_o, exp_seg());
    check("model_frame", bus.frame_o, m_frame);
    check("model_pending", bus.pending_o, m_pend);
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    bus.data_i = d; bus.dp_i = dp; bus.blank_i = bl; bus.load_i = 1'b1;
    @(negedge clk);
    bus.load_i = 1'b0;
  endtask

  task automatic wait_frame();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.frame_o === 1'b1) return;
    end
    check("wait_frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] an);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.disp_an_o === an) return;
    end
    check("wait_an_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.data_i = '0; bus.dp_i = '0; bus.blank_i = '0; bus.load_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", bus.disp_an_o, 4'hF);
    check("rst_seg", bus.disp_seg_o, 8'hFF);
    check("rst_pending", bus.pending_o, 1'b0);
    check("rst_frame", bus.frame_o, 1'b0);
    rst = 1'b0;

    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("idle_an", bus.disp_an_o, 4'hF);
      check("idle_seg", bus.disp_seg_o, 8'hFF);
    end
    @(negedge clk);
    check("first_an", bus.disp_an_o, 4'b1110);
    check("first_seg", bus.disp_seg_o, 8'hC0);
    check("first_frame", bus.frame_o, 1'b1);
    @(negedge clk);
    check("frame_one_cycle", bus.frame_o, 1'b0);

    // Mid-frame load holds off until the wrap.
    do_load(16'h1234, 4'b0000, 4'b0000);
    check("load_pending", bus.pending_o, 1'b1);
    check("load_no_change", bus.disp_seg_o, 8'hC0);
    wait_frame();
    check("d0_seg", bus.disp_seg_o, 8'h99);
    check("commit_pending", bus.pending_o, 1'b0);
    repeat (DIV) @(negedge clk);
    check("d1_an", bus.disp_an_o, 4'b1101);
    check("d1_seg", bus.disp_seg_o, 8'hB0);
    repeat (DIV) @(negedge clk);
    check("d2_seg", bus.disp_seg_o, 8'hA4);
    repeat (DIV) @(negedge clk);
    check("d3_an", bus.disp_an_o, 4'b0111);
    check("d3_seg", bus.disp_seg_o, 8'hF9);

    do_load(16'h1234, 4'b0010, 4'b0000);
    wait_frame();
    repeat (DIV) @(negedge clk);
    check("dp_seg", bus.disp_seg_o, 8'h30);

    do_load(16'h1234, 4'b0000, 4'b1000);
    wait_frame();
    repeat (3 * DIV) @(negedge clk);
    check("blank_an", bus.disp_an_o, 4'hF);
    check("blank_seg", bus.disp_seg_o, 8'hFF);

    // Last of two loads wins; a load on the wrap tick waits one more frame.
    do_load(16'h1111, 4'b0000, 4'b0000);
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_frame();
    check("twoload_seg", bus.disp_seg_o, 8'hA4);
    wait_an(4'b0111);
    repeat (DIV - 1) @(negedge clk);
    do_load(16'hABCD, 4'b0000, 4'b0000);
    check("coinc_frame", bus.frame_o, 1'b1);
    check("coinc_seg", bus.disp_seg_o, 8'hA4);
    check("coinc_pending", bus.pending_o, 1'b1);
    wait_frame();
    check("abcd_seg", bus.disp_seg_o, 8'hA1);
    check("abcd_pending", bus.pending_o, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        bus.data_i  = 16'($urandom);
        bus.dp_i    = 4'($urandom);
        bus.blank_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        bus.load_i  = 1'b1;
      end else begin
        bus.load_i  = 1'b0;
      end
    end
    @(negedge clk);
    bus.load_i = 1'b0;

    // Async reset in the digit-2 slot discards pending data.
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_frame();
    wait_an(4'b1011);
    do_load(16'h5678, 4'b0000, 4'b0000);
    check("pre_rst_pending", bus.pending_o, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_an", bus.disp_an_o, 4'hF);
    check("async_seg", bus.disp_seg_o, 8'hFF);
    check("async_pending", bus.pending_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_frame();
    check("post_rst_an", bus.disp_an_o, 4'b1110);
    check("post_rst_seg", bus.disp_seg_o, 8'hC0);
    check("post_rst_pending", bus.pending_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised time-multiplexed seven-segment display controller for the SCPU board top. It scans NUM_DIGITS common-anode digits, decodes one hex nibble per digit, and supports per-digit decimal point and blanking. A double-buffered load handshake makes display updates tear-free: new data is committed only at a frame boundary. The CPU top or a debug mux drives it, and it drives the board's anode and segment pins directly.

Parameters:
NUM_DIGITS, 8, number of scanned digits; legal range 2..16.
CLK_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); minimum 2.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
data_i  input  4*NUM_DIGITS  hex nibbles; digit k is data_i[4k+3:4k]; digit 0 is rightmost.
dp_i  input  NUM_DIGITS  decimal-point enable per digit; 1 = lit.
blank_i  input  NUM_DIGITS  blank request per digit; 1 = digit dark.
load_i  input  1  one-cycle strobe that captures data_i, dp_i and blank_i into the pending buffer.
pending_o  output  1  high while captured data waits for a frame boundary.
frame_o  output  1  one-cycle pulse on each frame start (digit 0 slot begins).
disp_an_o  output  NUM_DIGITS  anode select, active-low, one-hot-low.
disp_seg_o  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, rst=1): divider=0, digit index=NUM_DIGITS-1, display buffer and pending buffer all zero (blank bits 0), pending_o=0, frame_o=0, disp_an_o=all ones, disp_seg_o=8'hFF.
- Divider counts 0..CLK_DIV-1 and wraps. A tick is the cycle in which the divider equals CLK_DIV-1.
- On each tick, the index advances by 1 and wraps from NUM_DIGITS-1 to 0. The first tick after reset selects digit 0.
- All outputs are registered and update on the tick edge for the new index. Latency: the new slot is visible on the cycle after the tick.
- Anode for index i: bit i=0 and all other bits 1. A blanked digit drives disp_an_o all ones and disp_seg_o 8'hFF.
- Decode table (a..g, active-low, dp bit 1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - dp_i=1 clears bit7.
- Frame boundary is a tick where the index wraps to 0:
  - frame_o is high for exactly the one cycle in which the digit-0 outputs first appear.
  - If pending_o=1, the display buffer takes the pending buffer on that edge, pending_o clears, and the digit-0 outputs already use the new buffer contents (bypass).
- load_i:
  - Captures data_i, dp_i and blank_i into the pending buffer and sets pending_o on the next cycle.
  - A repeated load before the boundary overwrites the pending buffer; only the last load is displayed.
  - load_i coincident with a boundary tick: the transfer uses the pending contents held before that edge, if any. The new data is captured into the pending buffer and pending_o stays or becomes 1, so it commits at the next boundary.
- The display buffer is never written except at a boundary. Mid-frame loads never change lit digits.
- rst asserted mid-frame returns all state to reset values immediately, and pending data is discarded.

Optional Feature:
SEG7_DIM_EN
- Defined: adds input bright_i[3:0], sampled at each tick. Within a slot, the anode is asserted only while divider < ((bright_i+1)*CLK_DIV)>>4. Otherwise disp_an_o is all ones and disp_seg_o is FF. bright_i=15 gives full on-time.
- Undefined: bright_i is absent and the anode is asserted for the whole slot.

Test Plan:
- NUM_DIGITS=4, CLK_DIV=4, release rst at t0 -> outputs stay F/FF for 3 cycles; cycle 4: disp_an_o=4'b1110, disp_seg_o=C0, frame_o=1 for 1 cycle.
- load_i with data_i=16'h1234 mid-frame -> pending_o=1, digits unchanged until wrap; then digit0=99, digit1=B0, digit2=A4, digit3=F9; pending_o=0 on the same edge.
- dp_i=4'b0010 with data 16'h1234 -> digit1 shows 30; other digits unchanged.
- blank_i=4'b1000 -> during the digit3 slot, disp_an_o=4'b1111 and disp_seg_o=FF.
- Two loads (16'h1111, then 16'h2222) before the wrap -> all digits show A4. A load of 16'hABCD coincident with the wrap tick -> previous data commits now, and ABCD commits at the next frame.
- rst pulse during the digit2 slot with pending_o=1 -> outputs go F/FF and pending_o goes 0 asynchronously; after release, the display shows zeros (C0).
